reg_file_sb: RTL
================

# reg_file_sb

Parametrised integer register file for the pipeline's decode/writeback boundary: configurable data width and architectural register count, two write ports with fixed priority, per-register pending scoreboard, and optional write-to-read bypass. Sits between ID (reads, issue marking) and WB (port A retire, port B late/CSR writeback). Provides the hazard unit with per-operand busy flags so it no longer reconstructs them from pipeline tags.

## Interface
- XLEN, default `` `XLEN_64b ``: width code; data width W = 1<<(XLEN+4) (32 or 64).
- NREGS, default 32: architectural registers, legal values 16 (RV E) or 32.
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  reset; one clock; reset is asynchronous and active-high.
- i_clk_enable  in  1  gates all state updates (writes, issue, flush).
- i_rd_addr_1, i_rd_addr_2  in  5  read addresses.
- o_rd_data_1, o_rd_data_2  out  W  read data.
- o_rd_busy_1, o_rd_busy_2  out  1  operand has an outstanding producer.
- i_wa_en, i_wa_addr[4:0], i_wa_data[W-1:0]  in  write port A (retire), highest priority.
- i_wb_en, i_wb_addr[4:0], i_wb_data[W-1:0]  in  write port B (late/CSR writeback).
- i_issue_en  in  1  mark i_issue_addr pending.
- i_issue_addr  in  5  destination of issuing instruction.
- i_flush  in  1  clear all pending bits.
- i_dbg_sel  in  5  debug register select.
- o_dbg_data  out  W  contents of register i_dbg_sel (stored value, never bypassed).
- o_pending  out  NREGS  raw scoreboard vector, bit 0 always 0.

## Operation
- Storage: NREGS x W; x0 reads 0, never written, never pending.
- Address >= NREGS: read returns 0, busy 0; write and issue ignored.
- Write: port enabled, addr legal and nonzero, i_clk_enable=1 -> register takes data at posedge.
- Same address on both ports same cycle: port A data stored, port B dropped.
- Scoreboard: pending[r] set by issue; cleared by any accepted write to r.
- Issue and write to same r same cycle: pending stays set (new producer wins).
- i_flush: all pending cleared; flush beats a same-cycle issue; writes still performed.
- o_rd_busy_n = pending[addr] (see Configuration for bypass adjustment).
- i_clk_enable=0: no state change; reads remain live.

## Timing
- Reads, busy, debug: combinational from addresses and current state.
- Write visible in stored value one cycle after the write edge.
- Pending set/clear visible one cycle after the edge.
- Reset (async assert, any time incl. mid-write): all registers 0, all pending 0; outputs read 0, busy 0, o_pending 0 while reset held. Reset dominates clock enable.

## Configuration
- REG_FILE_BYPASS_EN defined: a read matching an accepted write in the same cycle returns that write's data (port A over port B), and busy for that operand is 0 unless a same-cycle issue targets it. Zero-latency WB->ID forwarding.
- Undefined: reads return stored value only; busy = pending[addr]; hazard unit must stall one extra cycle.

## Structure
- Reuse Constants.vh for XLEN codes; add REG_FILE_NREGS_RV32E (16) and REG_FILE_NREGS_RV32I (32) there.
- One sub-module: reg_file_scoreboard (pending vector, set/clear/flush priority).
- Storage, write arbitration and bypass muxing stay in reg_file_sb.

## Test plan
- Reset mid-run with x5=0xDEAD and pending[5]=1 -> next read x5=0, busy 0, o_pending=0.
- Port A x3=0x11, port B x3=0x22 same cycle -> next cycle x3 reads 0x11.
- Write x0=0xFFFF via A, issue x0 -> x0 reads 0, o_pending[0]=0.
- Issue x7; two cycles later write x7=0x5A via B with read of x7 same cycle -> bypass build: data 0x5A, busy 0; non-bypass: old data, busy 1, then 0x5A, busy 0 next cycle.
- Issue x9 with write x9 same cycle -> pending[9] stays 1; issue x9 with flush -> pending[9]=0.
- NREGS=16: write x20=0x1, i_clk_enable=0 write x4=0x2 -> x20 reads 0, x4 unchanged 0.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// +----------------------------------------------------------------------------+
// | reg_file_sb_pkg : XLEN codes, register-count constants, address helpers    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package reg_file_sb_pkg;

  localparam int XLEN_32B             = 1;
  localparam int XLEN_64B             = 2;
  localparam int REG_FILE_NREGS_RV32E = 16;
  localparam int REG_FILE_NREGS_RV32I = 32;

  function automatic int xlen_width(input int xlen);
    return 1 << (xlen + 4);
  endfunction

  // Nonzero and inside the implemented range: the only addresses that hold state.
  function automatic logic addr_writable(input logic [4:0] addr, input int nregs);
    return (addr != 5'd0) && (int'(addr) < nregs);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_sb_if.sv
// +----------------------------------------------------------------------------+
// | reg_file_sb_if : read, write, issue, flush and debug bus of reg_file_sb    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface reg_file_sb_if #(
  parameter int W     = 64,
  parameter int NREGS = 32
);

  logic [4:0]       i_rd_addr_1;
  logic [4:0]       i_rd_addr_2;
  logic [W-1:0]     o_rd_data_1;
  logic [W-1:0]     o_rd_data_2;
  logic             o_rd_busy_1;
  logic             o_rd_busy_2;
  logic             i_wa_en;
  logic [4:0]       i_wa_addr;
  logic [W-1:0]     i_wa_data;
  logic             i_wb_en;
  logic [4:0]       i_wb_addr;
  logic [W-1:0]     i_wb_data;
  logic             i_issue_en;
  logic [4:0]       i_issue_addr;
  logic             i_flush;
  logic [4:0]       i_dbg_sel;
  logic [W-1:0]     o_dbg_data;
  logic [NREGS-1:0] o_pending;

  modport master (
    output i_rd_addr_1, i_rd_addr_2, i_wa_en, i_wa_addr, i_wa_data,
           i_wb_en, i_wb_addr, i_wb_data, i_issue_en, i_issue_addr,
           i_flush, i_dbg_sel,
    input  o_rd_data_1, o_rd_data_2, o_rd_busy_1, o_rd_busy_2,
           o_dbg_data, o_pending
  );

  modport slave (
    input  i_rd_addr_1, i_rd_addr_2, i_wa_en, i_wa_addr, i_wa_data,
           i_wb_en, i_wb_addr, i_wb_data, i_issue_en, i_issue_addr,
           i_flush, i_dbg_sel,
    output o_rd_data_1, o_rd_data_2, o_rd_busy_1, o_rd_busy_2,
           o_dbg_data, o_pending
  );

endinterface

`default_nettype wire

// File: rtl/reg_file_sb_scoreboard.sv
// +----------------------------------------------------------------------------+
// | reg_file_scoreboard : pending vector; flush > issue set > write clear      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_file_scoreboard #(
  parameter int NREGS = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clk_enable,
  input  logic             i_flush,
  input  logic [NREGS-1:0] i_set,
  input  logic [NREGS-1:0] i_clr,
  output logic [NREGS-1:0] o_pending
);

  localparam logic [NREGS-1:0] c_x0_mask = {{(NREGS-1){1'b1}}, 1'b0};

  logic [NREGS-1:0] r_pending;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= '0;
    end else if (i_clk_enable) begin
      if (i_flush) begin
        r_pending <= '0;
      end else begin
        // A same-cycle issue re-arms the bit its retiring write would clear.
        r_pending <= ((r_pending & ~i_clr) | i_set) & c_x0_mask;
      end
    end
  end

  assign o_pending = r_pending;

endmodule

`default_nettype wire

// File: rtl/reg_file_sb.sv
// +----------------------------------------------------------------------------+
// | reg_file_sb : 2W/2R register file with pending scoreboard;                 |
// | optional same-cycle write->read bypass under REG_FILE_BYPASS_EN. Rev 1.0   |
// +----------------------------------------------------------------------------+
`default_nettype none

module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int XLEN  = XLEN_64B,
  parameter int NREGS = REG_FILE_NREGS_RV32I
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clk_enable,
  reg_file_sb_if.slave bus
);

  localparam int W  = xlen_width(XLEN);
  localparam int AW = $clog2(NREGS);
  localparam logic [NREGS-1:0] c_one = {{(NREGS-1){1'b0}}, 1'b1};

  logic [W-1:0]     r_regs [NREGS];
  logic             w_wa_ok;
  logic             w_wb_ok;
  logic             w_issue_ok;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_pending;

  assign w_wa_ok    = bus.i_wa_en && addr_writable(bus.i_wa_addr, NREGS);
  assign w_wb_ok    = bus.i_wb_en && addr_writable(bus.i_wb_addr, NREGS)
                      && !(w_wa_ok && (bus.i_wb_addr == bus.i_wa_addr));
  assign w_issue_ok = bus.i_issue_en && addr_writable(bus.i_issue_addr, NREGS);

  assign w_set = w_issue_ok ? (c_one << bus.i_issue_addr) : '0;
  assign w_clr = (w_wa_ok ? (c_one << bus.i_wa_addr) : '0)
               | (w_wb_ok ? (c_one << bus.i_wb_addr) : '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_clk_enable) begin
      if (w_wa_ok) r_regs[bus.i_wa_addr[AW-1:0]] <= bus.i_wa_data;
      if (w_wb_ok) r_regs[bus.i_wb_addr[AW-1:0]] <= bus.i_wb_data;
    end
  end

  reg_file_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clk_enable (i_clk_enable),
    .i_flush      (bus.i_flush),
    .i_set        (w_set),
    .i_clr        (w_clr),
    .o_pending    (w_pending)
  );

`ifdef REG_FILE_BYPASS_EN
  // Only writes that will actually commit at the next edge are forwarded.
  logic w_live;
  assign w_live = i_clk_enable && !i_rst;
`endif

  function automatic logic [W-1:0] rd_data(input logic [4:0] a);
    logic [W-1:0] d;
    d = addr_writable(a, NREGS) ? r_regs[a[AW-1:0]] : '0;
`ifdef REG_FILE_BYPASS_EN
    if (w_live && w_wb_ok && (bus.i_wb_addr == a)) d = bus.i_wb_data;
    if (w_live && w_wa_ok && (bus.i_wa_addr == a)) d = bus.i_wa_data;
`endif
    return d;
  endfunction

  function automatic logic rd_busy(input logic [4:0] a);
    logic b;
    b = addr_writable(a, NREGS) ? w_pending[a[AW-1:0]] : 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if (w_live && ((w_wa_ok && (bus.i_wa_addr == a)) || (w_wb_ok && (bus.i_wb_addr == a))))
      b = w_issue_ok && !bus.i_flush && (bus.i_issue_addr == a);
`endif
    return b;
  endfunction

  always_comb begin
    bus.o_rd_data_1 = rd_data(bus.i_rd_addr_1);
    bus.o_rd_data_2 = rd_data(bus.i_rd_addr_2);
    bus.o_rd_busy_1 = rd_busy(bus.i_rd_addr_1);
    bus.o_rd_busy_2 = rd_busy(bus.i_rd_addr_2);
    bus.o_dbg_data  = addr_writable(bus.i_dbg_sel, NREGS) ? r_regs[bus.i_dbg_sel[AW-1:0]] : '0;
  end

  assign bus.o_pending = w_pending;

endmodule

`default_nettype wire
